// File: rtl/rpc_cmd_scheduler.sv
// rtl/rpc_cmd_scheduler.sv - NUM_CH-way DRAM command arbiter onto the single RPC PHY command port
// Optional grant counters are compiled in with `define RPC_SCHED_PERF_EN.
module rpc_cmd_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CMD_WIDTH = 19,
    parameter int AGE_WIDTH = 8,
    parameter int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      init_done_i,
    input  logic                      arb_mode_i,
    input  logic [AGE_WIDTH-1:0]      age_limit_i,
    input  logic [NUM_CH-1:0]         req_valid_i,
    input  logic [NUM_CH*CMD_WIDTH-1:0] req_cmd_i,
    output logic [NUM_CH-1:0]         req_ready_o,
    output logic                      cmd_valid_o,
    output logic [CMD_WIDTH-1:0]      cmd_o,
    output logic [CH_IDX_W-1:0]       cmd_ch_o,
    input  logic                      cmd_ready_i,
    input  logic                      cmd_done_i,
`ifdef RPC_SCHED_PERF_EN
    input  logic                      perf_clr_i,
    output logic [NUM_CH*16-1:0]      grant_cnt_o,
`endif
    output logic                      busy_o,
    output logic [NUM_CH-1:0]         starve_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [CH_IDX_W-1:0]    rr_ptr;
    logic [AGE_WIDTH-1:0]   age_q [NUM_CH];

    logic                   grant;
    logic                   starve_any;
    logic [CH_IDX_W-1:0]    starve_win;
    logic [CH_IDX_W-1:0]    fixed_win;
    logic [CH_IDX_W-1:0]    rr_win;
    logic [CH_IDX_W-1:0]    win;
    int                     rr_idx;

    // Starvation flags straight from the age registers; a zero limit turns aging off.
    always_comb begin
        starve_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            starve_o[c] = (age_limit_i != '0) && (age_q[c] >= age_limit_i);
        end
    end

    // Winner selection: starving channels first, then fixed priority or round-robin.
    always_comb begin
        starve_any = 1'b0;
        starve_win = '0;
        fixed_win  = '0;
        rr_win     = '0;
        rr_idx     = 0;
        // Descending scans so the last hit (lowest index / nearest to pointer) sticks.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (req_valid_i[c] && starve_o[c]) begin
                starve_any = 1'b1;
                starve_win = CH_IDX_W'(c);
            end
            if (req_valid_i[c]) begin
                fixed_win = CH_IDX_W'(c);
            end
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= NUM_CH) begin
                rr_idx = rr_idx - NUM_CH;
            end
            if (req_valid_i[rr_idx]) begin
                rr_win = CH_IDX_W'(rr_idx);
            end
        end
        win = starve_any ? starve_win : (arb_mode_i ? rr_win : fixed_win);
    end

    // Accept is combinational and only ever offered from IDLE after init.
    always_comb begin
        grant       = (state == IDLE) && init_done_i && (|req_valid_i);
        req_ready_o = '0;
        if (grant) begin
            req_ready_o = NUM_CH'(1) << win;
        end
    end

    // Main FSM: one command in flight from accept until the PHY reports done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cmd_valid_o <= 1'b0;
            cmd_o       <= '0;
            cmd_ch_o    <= '0;
            busy_o      <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cmd_o       <= req_cmd_i[int'(win)*CMD_WIDTH +: CMD_WIDTH];
                        cmd_ch_o    <= win;
                        cmd_valid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        rr_ptr      <= (win == CH_IDX_W'(NUM_CH - 1)) ? '0 : win + CH_IDX_W'(1);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        if (cmd_done_i) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state  <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (cmd_done_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    cmd_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Per-channel wait ages: cleared when idle, not requesting or granted; saturating otherwise.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i || !init_done_i || !req_valid_i[c] || req_ready_o[c]) begin
                age_q[c] <= '0;
            end else if (age_q[c] != {AGE_WIDTH{1'b1}}) begin
                age_q[c] <= age_q[c] + AGE_WIDTH'(1);
            end
        end
    end

`ifdef RPC_SCHED_PERF_EN
    logic [15:0] grant_cnt_q [NUM_CH];

    // Saturating grant counters; a clear takes precedence over a same-cycle grant.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i || perf_clr_i) begin
                grant_cnt_q[c] <= '0;
            end else if (req_ready_o[c] && (grant_cnt_q[c] != 16'hFFFF)) begin
                grant_cnt_q[c] <= grant_cnt_q[c] + 16'd1;
            end
        end
    end

    // Flatten counters onto the output bus, channel c at [c*16 +: 16].
    always_comb begin
        grant_cnt_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_cnt_o[c*16 +: 16] = grant_cnt_q[c];
        end
    end
`endif

endmodule
